mem_port_arbiter: RTL and testbench

Shares the single 2-cycle pipelined memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). It picks one requester per cycle and drives the memory address/write bus. It tracks in-flight requests in a 2-deep owner pipeline and routes each returning word back to its requester. The fetch stall and data stall signals are derived from its grants, and a fetch flush squashes in-flight fetch responses.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_owner_pipe.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, owner encoding and owner-pipeline entry
// type for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned STARVE_W = 4;
  // Memory read data is valid this many enabled cycles after issue.
  localparam int unsigned MEM_LAT  = 2;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } own_entry_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared port.
//   slave  : arbiter view (takes requests, drives grants/responses/memory bus)
//   master : requester/memory view
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_grant;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_grant;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output if_grant, if_rvalid, if_rdata, d_grant, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  if_grant, if_rvalid, if_rdata, d_grant, d_rvalid, d_rdata,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_port_owner_pipe.sv
// mem_port_owner_pipe: MEM_LAT-deep shift register recording who owns each
// in-flight memory access. Fetch-owned entries are squashed by flush.
//   clk, rst_n : clock, async active-low reset
//   clk_en     : advance enable (frozen when low)
//   flush      : kill fetch-owned entries
//   issue      : entry entering the pipe this cycle
//   resp_c     : oldest entry, already squashed by flush
module mem_port_owner_pipe
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       flush,
  input  own_entry_t issue,
  output own_entry_t resp_c
);

  own_entry_t stage_q [MEM_LAT];

  // Flush view of an entry: fetch-owned entries lose their valid bit.
  function automatic own_entry_t squash(input own_entry_t e, input logic fl);
    own_entry_t r;
    r       = e;
    r.valid = e.valid & ~(fl & (e.owner == OWN_FETCH));
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_LAT); i++) stage_q[i] <= '0;
    end else if (clk_en) begin
      stage_q[0] <= issue;
      for (int i = 1; i < int'(MEM_LAT); i++) stage_q[i] <= squash(stage_q[i-1], flush);
    end
  end

  assign resp_c = squash(stage_q[MEM_LAT-1], flush);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined memory port between fetch and data.
// Picks one requester per cycle, drives the memory bus, and routes each
// returning word to its owner. Optional fetch anti-starvation under macro
// MEM_PORT_ARB_STARVE_EN (undefined: strict data priority).
//   clk, rst_n : clock, async active-low reset
//   clk_en     : global enable, all state frozen and no grants when low
//   bus        : fetch/data request+response and memory bus (slave modport)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic       arb_en_c;
  logic       starve_hit_c;
  logic       fetch_win_c;
  logic       data_win_c;
  own_entry_t issue_c;
  own_entry_t resp_c;
  logic       resp_live_c;

  // Reset also blanks grants so every output reads 0 while rst_n is low.
  assign arb_en_c = clk_en & rst_n;

`ifdef MEM_PORT_ARB_STARVE_EN
  logic [STARVE_W-1:0] starve_cnt_q;

  assign starve_hit_c = (starve_cnt_q == STARVE_LIM);

  // Counts consecutive denied fetch cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (clk_en) begin
      if (!bus.if_req || fetch_win_c) begin
        starve_cnt_q <= '0;
      end else if (!starve_hit_c) begin
        starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
      end
    end
  end
`else
  // Strict data priority: the starve limit has no effect.
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^STARVE_LIM;
  assign starve_hit_c      = 1'b0;
`endif

  // Data wins by default; fetch wins when data is idle or fetch is starved.
  assign fetch_win_c = arb_en_c & bus.if_req & ~bus.if_flush & (~bus.d_req | starve_hit_c);
  assign data_win_c  = arb_en_c & bus.d_req & ~fetch_win_c;

  assign bus.if_grant = fetch_win_c;
  assign bus.d_grant  = data_win_c;

  // Memory bus follows the winner, all zero when idle.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = '0;
    bus.mem_wdata = '0;
    if (data_win_c) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_we    = bus.d_we;
      bus.mem_wdata = bus.d_wdata;
    end else if (fetch_win_c) begin
      bus.mem_addr  = bus.if_addr;
    end
  end

  always_comb begin
    issue_c       = '0;
    issue_c.valid = fetch_win_c | data_win_c;
    issue_c.owner = data_win_c ? OWN_DATA : OWN_FETCH;
  end

  mem_port_owner_pipe u_owner_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .flush  (bus.if_flush),
    .issue  (issue_c),
    .resp_c (resp_c)
  );

  // A frozen cycle is not a delivery cycle; the word is presented again once enabled.
  assign resp_live_c = resp_c.valid & clk_en;

  assign bus.if_rvalid = resp_live_c & (resp_c.owner == OWN_FETCH);
  assign bus.d_rvalid  = resp_live_c & (resp_c.owner == OWN_DATA);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a response
// scoreboard and a 2-stage memory model gated by clk_en.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic        is_data;
    logic        is_write;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory model: read data for the address issued two enabled cycles ago.
  logic [31:0] ma1, ma2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma1 <= '0;
      ma2 <= '0;
    end else if (clk_en) begin
      ma1 <= bus.mem_addr;
      ma2 <= ma1;
    end
  end
  assign bus.mem_rdata = mem_word(ma2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_data, input logic is_write, input logic [31:0] addr);
    exp_t e;
    e.is_data  = is_data;
    e.is_write = is_write;
    e.data     = mem_word(addr);
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then score any response this cycle.
  task automatic settle();
    exp_t e;
    #1;
    if (bus.if_rvalid || bus.d_rvalid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_owner", 32'({bus.if_rvalid, bus.d_rvalid}), e.is_data ? 32'd1 : 32'd2);
        if (!e.is_write)
          chk("resp_rdata", e.is_data ? bus.d_rdata : bus.if_rdata, e.data);
      end
    end
    if (!bus.if_rvalid) chk("if_rdata_idle", bus.if_rdata, 32'd0);
    if (!bus.d_rvalid)  chk("d_rdata_idle", bus.d_rdata, 32'd0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_addr   = '0;
    bus.d_we     = '0;
    bus.d_wdata  = '0;
  endtask

  initial begin
    logic exp_fg;

    // Reset with requests pending: everything must read 0.
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.d_req  = 1'b1; bus.d_addr  = 32'h1000;
    #2;
    chk("rst_if_grant", 32'(bus.if_grant), 32'd0);
    chk("rst_d_grant", 32'(bus.d_grant), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    idle();
    next();

    // Lone fetch read.
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    settle();
    chk("f1_if_grant", 32'(bus.if_grant), 32'd1);
    chk("f1_d_grant", 32'(bus.d_grant), 32'd0);
    chk("f1_mem_addr", bus.mem_addr, 32'h400);
    chk("f1_mem_we", 32'(bus.mem_we), 32'd0);
    push_exp(1'b0, 1'b0, 32'h400);
    next();
    idle();
    settle();
    chk("f1_c1_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    next();
    settle();
    chk("f1_c2_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    next();

    // Data and fetch together: data first, fetch next cycle.
    bus.d_req = 1'b1; bus.d_addr = 32'h1000;
    bus.if_req = 1'b1; bus.if_addr = 32'h404;
    settle();
    chk("mix_c0_d_grant", 32'(bus.d_grant), 32'd1);
    chk("mix_c0_if_grant", 32'(bus.if_grant), 32'd0);
    chk("mix_c0_mem_addr", bus.mem_addr, 32'h1000);
    push_exp(1'b1, 1'b0, 32'h1000);
    next();
    bus.d_req = 1'b0;
    settle();
    chk("mix_c1_if_grant", 32'(bus.if_grant), 32'd1);
    chk("mix_c1_mem_addr", bus.mem_addr, 32'h404);
    push_exp(1'b0, 1'b0, 32'h404);
    next();
    idle();
    settle();
    chk("mix_c2_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    next();
    settle();
    chk("mix_c3_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    next();

    // Both held high: starve override grants fetch on cycle 4 only.
    bus.d_req = 1'b1; bus.d_addr = 32'h1100;
    bus.if_req = 1'b1; bus.if_addr = 32'h408;
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_PORT_ARB_STARVE_EN
      exp_fg = (k == 4);
`else
      exp_fg = 1'b0;
`endif
      settle();
      chk($sformatf("starve_k%0d_if_grant", k), 32'(bus.if_grant), 32'(exp_fg));
      chk($sformatf("starve_k%0d_d_grant", k), 32'(bus.d_grant), 32'(!exp_fg));
      chk($sformatf("starve_k%0d_mem_addr", k), bus.mem_addr, exp_fg ? 32'h408 : 32'h1100);
      push_exp(!exp_fg, 1'b0, exp_fg ? 32'h408 : 32'h1100);
      next();
    end
    idle();
    settle(); next();
    settle(); next();

    // Two fetches then flush: neither returns.
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    settle();
    chk("fl_a_c0_if_grant", 32'(bus.if_grant), 32'd1);
    next();
    bus.if_addr = 32'h504;
    settle();
    chk("fl_a_c1_if_grant", 32'(bus.if_grant), 32'd1);
    next();
    idle();
    bus.if_flush = 1'b1;
    settle();
    chk("fl_a_c2_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    next();
    bus.if_flush = 1'b0;
    settle();
    chk("fl_a_c3_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    next();

    // Fetch, then data, then flush: data still returns; flush blocks fetch grant.
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    settle();
    chk("fl_b_c0_if_grant", 32'(bus.if_grant), 32'd1);
    next();
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = 32'h1200;
    settle();
    chk("fl_b_c1_d_grant", 32'(bus.d_grant), 32'd1);
    push_exp(1'b1, 1'b0, 32'h1200);
    next();
    bus.d_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h700;
    bus.if_flush = 1'b1;
    settle();
    chk("fl_b_c2_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("fl_b_c2_if_grant", 32'(bus.if_grant), 32'd0);
    next();
    bus.if_flush = 1'b0;
    settle();
    chk("fl_b_c3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("fl_b_c3_if_grant", 32'(bus.if_grant), 32'd1);
    push_exp(1'b0, 1'b0, 32'h700);
    next();
    idle();
    settle(); next();
    settle();
    chk("fl_b_c5_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    next();

    // Freeze three cycles between grant and response.
    bus.if_req = 1'b1; bus.if_addr = 32'h800;
    settle();
    chk("frz_c0_if_grant", 32'(bus.if_grant), 32'd1);
    push_exp(1'b0, 1'b0, 32'h800);
    next();
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = 32'h1300;
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("frz_off%0d_d_grant", k), 32'(bus.d_grant), 32'd0);
      chk($sformatf("frz_off%0d_mem_addr", k), bus.mem_addr, 32'd0);
      chk($sformatf("frz_off%0d_if_rvalid", k), 32'(bus.if_rvalid), 32'd0);
      next();
    end
    clk_en = 1'b1;
    settle();
    chk("frz_e1_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("frz_e1_d_grant", 32'(bus.d_grant), 32'd1);
    push_exp(1'b1, 1'b0, 32'h1300);
    next();
    idle();
    settle();
    chk("frz_e2_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    next();
    settle();
    chk("frz_e3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    next();

    // Reset mid-flight: outputs drop at once, nothing stale afterwards.
    bus.if_req = 1'b1; bus.if_addr = 32'h900;
    settle();
    next();
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = 32'h1400;
    settle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_d_grant", 32'(bus.d_grant), 32'd0);
    chk("mrst_mem_addr", bus.mem_addr, 32'd0);
    chk("mrst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle();
    next();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("mrst_post%0d_rvalid", k), 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
      next();
    end

    // Full-word data write, acked two cycles later.
    bus.d_req = 1'b1; bus.d_we = 4'hF;
    bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
    settle();
    chk("wr_c0_d_grant", 32'(bus.d_grant), 32'd1);
    chk("wr_c0_mem_we", 32'(bus.mem_we), 32'hF);
    chk("wr_c0_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("wr_c0_mem_addr", bus.mem_addr, 32'h2000);
    push_exp(1'b1, 1'b1, 32'h2000);
    next();
    idle();
    settle();
    chk("wr_c1_mem_we", 32'(bus.mem_we), 32'd0);
    chk("wr_c1_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    next();
    settle();
    chk("wr_c2_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    next();

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
